// File: rtl/spi_regmap_pkg.sv
// Shared constants and types for the 16-bit SPI register-map host.
// Imported by the frame engine and the command sequencer.
package spi_regmap_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int ADDR_W = 10;
    localparam int CNT_W = 6;

    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b00;

    localparam int REG_ID = 0;
    localparam logic [15:0] ID_VALUE = 16'h4A53;
    localparam int REG_SERVO0 = 25;
    localparam int REG_PID_AT_GOAL = 45;
    localparam int NUM_REGS = 46;

    localparam logic [15:0] RD_WORD_CMD = {OP_READ, 14'b0};
    localparam logic [15:0] NOP_WORD = {OP_NOP, 14'b0};

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD,
        RD_WORD
    } host_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_LEAD,
        F_SHIFT,
        F_TRAIL,
        F_GAP
    } frame_state_t;

    function automatic logic [15:0] wr_cmd_word(input logic [ADDR_W-1:0] addr);
        return {OP_WRITE, 4'b0, addr};
    endfunction

endpackage

// File: rtl/spi_host_master_frame_engine.sv
// One 16-bit SPI frame per start pulse: LEAD, 16 bit cells, TRAIL, GAP.
// SPI_CLK idles high; MISO is captured on the cycle SPI_CLK is driven low.
module spi_frame_engine
    import spi_regmap_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tx_word,
    input  logic        miso,
    output logic        spi_clk,
    output logic        ssel,
    output logic        mosi,
    output logic        frame_done,
    output logic        rx_last,
    output logic [15:0] rx_word
);

    localparam logic [15:0] HP_LOAD = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP - 1);

    frame_state_t state, state_n;
    logic [15:0] timer, timer_n;
    logic [3:0] bitcnt, bitcnt_n;
    logic [15:0] tx, tx_n;
    logic [14:0] rx, rx_n;
    logic sclk_n, ssel_n;
    logic tick, fall, go;

    assign tick = (timer == 16'd0);
    assign fall = tick && ((state == F_LEAD) ||
                  (state == F_SHIFT && spi_clk && bitcnt != 4'd15));
    assign go = start && (state == F_IDLE || frame_done);

    // The shift register MSB is the live MOSI bit.
    assign mosi = tx[15];
    assign rx_word = {rx, miso};
    assign rx_last = fall && (state == F_SHIFT) && (bitcnt == 4'd14);
    assign frame_done = (state == F_GAP) && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= F_IDLE;
            timer <= 16'd0;
            bitcnt <= 4'd0;
            tx <= 16'd0;
            rx <= 15'd0;
            spi_clk <= 1'b1;
            ssel <= 1'b1;
        end else begin
            state <= state_n;
            timer <= timer_n;
            bitcnt <= bitcnt_n;
            tx <= tx_n;
            rx <= rx_n;
            spi_clk <= sclk_n;
            ssel <= ssel_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = tick ? timer : timer - 16'd1;
        bitcnt_n = bitcnt;
        tx_n = tx;
        rx_n = rx;
        sclk_n = spi_clk;
        ssel_n = ssel;
        if (fall) begin
            rx_n = rx_word[14:0];
            sclk_n = 1'b0;
            timer_n = HP_LOAD;
            state_n = F_SHIFT;
            bitcnt_n = (state == F_LEAD) ? 4'd0 : bitcnt + 4'd1;
        end
        unique case (state)
            F_SHIFT: begin
                if (tick && !spi_clk) begin
                    sclk_n = 1'b1;
                    tx_n = {tx[14:0], 1'b0};
                    timer_n = HP_LOAD;
                end else if (tick && bitcnt == 4'd15) begin
                    state_n = F_TRAIL;
                    timer_n = HP_LOAD;
                end
            end
            F_TRAIL: begin
                if (tick) begin
                    ssel_n = 1'b1;
                    state_n = F_GAP;
                    timer_n = GAP_LOAD;
                end
            end
            F_GAP: begin
                if (tick) state_n = F_IDLE;
            end
            default: ;
        endcase
        if (go) begin
            state_n = F_LEAD;
            ssel_n = 1'b0;
            sclk_n = 1'b1;
            tx_n = tx_word;
            timer_n = HP_LOAD;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// Command sequencer: single writes become two frames, read bursts become
// N read frames plus a closing NOP, with returned words strobed out.
module spi_host_master
    import spi_regmap_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP = 8
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [5:0]  cmd_rd_count,
    output logic        rd_valid,
    output logic [5:0]  rd_index,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        busy,
    output logic        SPI_CLK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO
);

    host_state_t state, state_n;
    logic [5:0] fcnt, fcnt_n, fnext;
    logic [5:0] n_q;
    logic [15:0] wdata_q;
    logic start, frame_done, rx_last;
    logic [15:0] tx_word, rx_word;
    logic accept;

    assign cmd_ready = (state == IDLE);
    assign busy = (state != IDLE);
    assign accept = cmd_valid && cmd_ready;
    assign fnext = fcnt + 6'd1;

    spi_frame_engine #(
        .HALF_PERIOD(HALF_PERIOD),
        .GAP(GAP)
    ) u_engine (
        .clk(SYS_CLK),
        .rst_n(SYS_RST_N),
        .start(start),
        .tx_word(tx_word),
        .miso(MISO),
        .spi_clk(SPI_CLK),
        .ssel(SSEL),
        .mosi(MOSI),
        .frame_done(frame_done),
        .rx_last(rx_last),
        .rx_word(rx_word)
    );

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state <= IDLE;
            fcnt <= 6'd0;
            n_q <= 6'd1;
            wdata_q <= 16'd0;
            rd_valid <= 1'b0;
            rd_index <= 6'd0;
            rd_data <= 16'd0;
        end else begin
            state <= state_n;
            fcnt <= fcnt_n;
            if (accept) begin
                wdata_q <= cmd_wdata;
                n_q <= (cmd_rd_count == 6'd0) ? 6'd1 : cmd_rd_count;
            end
            // Frame k carries register k-1; frame 0 MISO is junk.
            rd_valid <= rx_last && (state == RD_WORD);
            if (rx_last && state == RD_WORD) begin
                rd_index <= fcnt - 6'd1;
                rd_data <= rx_word;
            end
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n = fcnt;
        start = 1'b0;
        tx_word = NOP_WORD;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    start = 1'b1;
                    fcnt_n = 6'd0;
                    if (cmd_write) begin
                        state_n = WR_CMD;
                        tx_word = wr_cmd_word(cmd_addr);
                    end else begin
                        state_n = RD_CMD;
                        tx_word = RD_WORD_CMD;
                    end
                end
            end
            WR_CMD: begin
                if (frame_done) begin
                    start = 1'b1;
                    tx_word = wdata_q;
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (frame_done) begin
                    done = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_CMD: begin
                if (frame_done) begin
                    start = 1'b1;
                    fcnt_n = 6'd1;
                    tx_word = (n_q > 6'd1) ? RD_WORD_CMD : NOP_WORD;
                    state_n = RD_WORD;
                end
            end
            RD_WORD: begin
                if (frame_done) begin
                    if (fcnt == n_q) begin
                        done = 1'b1;
                        state_n = IDLE;
                    end else begin
                        start = 1'b1;
                        fcnt_n = fnext;
                        tx_word = (fnext < n_q) ? RD_WORD_CMD : NOP_WORD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: slave register model on the SPI pins,
// frame and read-word scoreboards, and command/reset corner cases.
module tb_spi_host_master;

    localparam int HP = 4;
    localparam int GP = 8;
    localparam int FRAME = 34 * HP + GP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_write = 1'b0;
    logic [9:0] cmd_addr = 10'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic [5:0] cmd_rd_count = 6'd0;
    logic miso = 1'b0;
    logic cmd_ready, rd_valid, done, busy, sclk, ssel, mosi;
    logic [5:0] rd_index;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    spi_host_master #(.HALF_PERIOD(HP), .GAP(GP)) dut (
        .SYS_CLK(clk),
        .SYS_RST_N(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_rd_count(cmd_rd_count),
        .rd_valid(rd_valid),
        .rd_index(rd_index),
        .rd_data(rd_data),
        .done(done),
        .busy(busy),
        .SPI_CLK(sclk),
        .SSEL(ssel),
        .MOSI(mosi),
        .MISO(miso)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] frame_q[$];
    logic [21:0] rd_q[$];
    logic [15:0] exp_regs[64];
    logic [15:0] sregs[64];

    function automatic logic [15:0] init_reg(input int i);
        if (i == 0) return 16'h4A53;
        if (i == 1) return 16'h00A5;
        if (i == 2) return 16'h0123;
        if (i < 46) return 16'(i * 257);
        return 16'h0000;
    endfunction

    // Slave model: decodes MOSI per SSEL-low frame, answers reads on MISO,
    // and checks SPI_CLK phase lengths, SSEL gap and MOSI stability.
    int nb = 0, run = 0, gap_run = 100, frames_seen = 0, ridx = 0;
    bit tbad = 0, wr_pend = 0, rd_act = 0;
    logic [15:0] rxw = 16'd0, osh = 16'd0, outw = 16'd0;
    logic [9:0] waddr = 10'd0;
    logic p_sclk = 1'b1, p_ssel = 1'b1, p_mosi = 1'b0;

    task automatic slave_frame(input logic [15:0] w);
        if (frame_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %h expected none", w);
        end else begin
            check("mosi_frame", int'(w), int'(frame_q.pop_front()));
        end
        if (wr_pend) begin
            if (waddr < 10'd46) sregs[waddr[5:0]] = w;
            wr_pend = 0;
        end else if (w[15:14] == 2'b01) begin
            waddr = w[9:0];
            wr_pend = 1;
        end else if (w[15:14] == 2'b10) begin
            if (!rd_act) begin
                rd_act = 1;
                ridx = 0;
            end
            outw = (ridx < 46) ? sregs[ridx] : 16'h0000;
            ridx++;
        end else begin
            rd_act = 0;
            outw = 16'h0000;
        end
    endtask

    always @(negedge clk) begin
        if (p_ssel && !ssel) begin
            check("ssel_gap", int'(gap_run >= GP), 1);
            nb = 0;
            tbad = 0;
            run = 1;
            osh = outw;
            miso = outw[15];
        end else if (!ssel) begin
            if (sclk == p_sclk) begin
                run++;
            end else begin
                if (run != HP) tbad = 1;
                run = 1;
                if (!sclk) begin
                    if (mosi !== p_mosi) tbad = 1;
                    rxw = {rxw[14:0], mosi};
                    nb++;
                    osh = {osh[14:0], 1'b0};
                    miso = osh[15];
                end
            end
        end else if (!p_ssel && ssel) begin
            if (nb == 16) begin
                frames_seen++;
                check("sclk_phase", int'(tbad), 0);
                check("trail_len", run, 2 * HP);
                slave_frame(rxw);
            end
            gap_run = 0;
        end
        if (ssel) gap_run++;
        p_sclk = sclk;
        p_ssel = ssel;
        p_mosi = mosi;
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %0d/%h expected none", rd_index, rd_data);
            end else begin
                logic [21:0] e;
                e = rd_q.pop_front();
                check("rd_index", int'(rd_index), int'(e[21:16]));
                check("rd_data", int'(rd_data), int'(e[15:0]));
            end
        end
    end

    typedef struct {
        bit wr;
        logic [9:0] addr;
        logic [15:0] wdata;
        logic [5:0] cnt;
        int frames;
        int cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic push_expect(input vec_t v);
        int n;
        n = (v.cnt == 6'd0) ? 1 : int'(v.cnt);
        if (v.wr) begin
            frame_q.push_back({2'b01, 4'b0000, v.addr});
            frame_q.push_back(v.wdata);
            if (v.addr < 10'd46) exp_regs[v.addr[5:0]] = v.wdata;
        end else begin
            for (int k = 0; k < n; k++) frame_q.push_back(16'h8000);
            frame_q.push_back(16'h0000);
            for (int k = 0; k < n; k++)
                rd_q.push_back({6'(k), (k < 46) ? exp_regs[k] : 16'h0000});
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 8000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic drive(input vec_t v);
        cmd_write = v.wr;
        cmd_addr = v.addr;
        cmd_wdata = v.wdata;
        cmd_rd_count = v.cnt;
        cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v);
        int cyc, f0;
        f0 = frames_seen;
        push_expect(v);
        check("ready_idle", int'(cmd_ready), 1);
        drive(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        wait_done(cyc);
        check("done_cycle", cyc, v.cycles);
        check("frame_count", frames_seen - f0, v.frames);
        check("frame_q_empty", frame_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        @(posedge clk);
        #1;
        check("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int cyc, dcount;
        for (int i = 0; i < 64; i++) begin
            exp_regs[i] = init_reg(i);
            sregs[i] = init_reg(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", int'(sclk), 1);
        check("rst_ssel", int'(ssel), 1);
        check("rst_mosi", int'(mosi), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_index", int'(rd_index), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{1'b1, 10'd25, 16'h0400, 6'd0, 2, 2 * FRAME};
        vecs[1] = '{1'b0, 10'd0, 16'h0000, 6'd3, 4, 4 * FRAME};
        vecs[2] = '{1'b0, 10'd9, 16'hFFFF, 6'd0, 2, 2 * FRAME};
        vecs[3] = '{1'b1, 10'd3, 16'hBEEF, 6'd0, 2, 2 * FRAME};
        vecs[4] = '{1'b0, 10'd0, 16'h0000, 6'd5, 6, 6 * FRAME};
        vecs[5] = '{1'b1, 10'h3FF, 16'h1234, 6'd0, 2, 2 * FRAME};
        vecs[6] = '{1'b0, 10'd0, 16'h0000, 6'd48, 49, 49 * FRAME};
        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);
        check("slave_reg25", int'(sregs[25]), 16'h0400);
        check("slave_reg3", int'(sregs[3]), 16'hBEEF);

        // cmd_valid mid-read is ignored; a write offered on done waits a cycle.
        v = '{1'b0, 10'd0, 16'h0000, 6'd2, 3, 3 * FRAME};
        push_expect(v);
        drive(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        check("ready_mid_read", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(cyc);
        check("mid_read_done", int'(done), 1);
        v = '{1'b1, 10'd5, 16'h5555, 6'd0, 2, 2 * FRAME};
        drive(v);
        check("ready_on_done", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("not_accepted_on_done", int'(busy), 0);
        check("ready_after_done", int'(cmd_ready), 1);
        push_expect(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("accepted_next", int'(busy), 1);
        wait_done(cyc);
        check("b2b_done_cycle", cyc, 2 * FRAME);
        check("b2b_frame_q", frame_q.size(), 0);
        check("slave_reg5", int'(sregs[5]), 16'h5555);
        @(posedge clk);
        #1;

        // Reset during bit 7 of a write command frame.
        v = '{1'b1, 10'd7, 16'h7777, 6'd0, 0, 0};
        drive(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (62) @(posedge clk);
        #1;
        check("bit7_sclk_low", int'(sclk), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ssel", int'(ssel), 1);
        check("rst_mid_sclk", int'(sclk), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ready", int'(cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("no_done_after_rst", dcount, 0);
        check("slave_reg7", int'(sregs[7]), int'(init_reg(7)));
        run_cmd('{1'b0, 10'd0, 16'h0000, 6'd2, 3, 3 * FRAME});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
SPI master for the 16-bit register-map protocol used by the board's FPGA register slave. It runs on the same system clock. It turns single-register write commands and sequential read-burst commands into framed 16-bit SPI transfers, and returns read words on a valid-strobed bus. It serves as the host-side model and bench driver, and as the bridge for on-chip hosts that access the same register map.

Parameters:
HALF_PERIOD, 4, SYS_CLK cycles per SPI_CLK half-period; minimum 4, because the slave uses a 3-stage synchroniser.
GAP, 8, SYS_CLK cycles SSEL is held high between frames; minimum 4.

Ports:
SYS_CLK  in  1  system clock
SYS_RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = single write, 0 = read burst
cmd_addr  in  10  write address; ignored for reads
cmd_wdata  in  16  write data
cmd_rd_count  in  6  number of registers to read, starting at reg 0; 0 is treated as 1
rd_valid  out  1  one-cycle strobe per returned read word
rd_index  out  6  register index of rd_data
rd_data  out  16  returned register word
done  out  1  one-cycle pulse when the command completes
busy  out  1  high from acceptance until done
SPI_CLK  out  1  SPI clock; idles high
SSEL  out  1  active-low slave select
MOSI  out  1  master out, MSB first
MISO  in  1  slave out

Behaviour:
- Reset values: SPI_CLK=1, SSEL=1, MOSI=0, cmd_ready=1, busy=0, done=0, rd_valid=0, rd_index=0, rd_data=0. Reset mid-frame forces these values immediately.
- Reset mid-frame sends no recovery frame. A slave left in write state consumes the next word as data, so software must reissue the command.
- Frame format: one 16-bit word per SSEL-low period. Frame state sequence is LEAD, SHIFT, TRAIL, GAP.
- LEAD: SSEL=0, SPI_CLK=1, MOSI = word bit 15, held for HALF_PERIOD cycles.
- SHIFT: 16 bits. Each bit: SPI_CLK=0 for HALF_PERIOD cycles, then SPI_CLK=1 for HALF_PERIOD cycles.
- MISO is sampled on the SYS_CLK where SPI_CLK is driven 1→0 (before the fall).
- MOSI advances to the next bit on the same cycle SPI_CLK rises.
- TRAIL: SPI_CLK=1 for HALF_PERIOD cycles, then SSEL=1.
- GAP: SSEL=1 for GAP cycles.
- Frame length = 34*HALF_PERIOD + GAP; 144 cycles at the defaults.
- Opcode is word bits [15:14]: READ=2'b10, WRITE=2'b01, NOP=2'b00.
- Write command: frame 0 = {2'b01, 4'b0, cmd_addr}; frame 1 = cmd_wdata. MISO is discarded. done pulses on the last GAP cycle of frame 1.
- Read command with N = max(cmd_rd_count, 1): N+1 frames.
  - Frames 0..N-1 send 0x8000; frame N sends 0x0000, which returns the slave to idle.
  - Frame 0's MISO is discarded.
  - Frame k (k≥1) returns reg k-1: rd_valid pulses one cycle after that frame's 16th sample, with rd_index=k-1 and rd_data = the sampled word.
  - done pulses on the last GAP cycle of frame N.
- Indices above 45 are legal; the slave returns 0 for them.
- Commands: cmd_ready=0 while busy. cmd_valid during busy is ignored and not queued. cmd_write, cmd_addr, cmd_wdata and cmd_rd_count are captured at acceptance.
- Back-to-back commands: a command offered on the done cycle is not accepted. It is accepted on the following cycle, which is IDLE.
- Top-level states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WORD. The counters are a frame counter (6 bits), a bit counter (4 bits) and a half-period/gap timer.

Decomposition:
- Shared package spi_regmap_pkg: SPI_WORD_W=16, ADDR_W=10, opcodes OP_READ/OP_WRITE/OP_NOP, REG_ID=0 with ID value 16'h4A53, and register address constants (REG_SERVO0=25 … REG_PID_AT_GOAL=45, NUM_REGS=46).
- One sub-module, spi_frame_engine: sends one 16-bit word and captures one 16-bit word per start pulse, generating SPI_CLK, SSEL and MOSI. It provides a frame_done strobe and the rx word.
- The top level sequences frames and handles the command/read interface.

Test Plan:
- Write: cmd_write=1, addr=25, wdata=0x0400 → MOSI frames 0x4019 then 0x0400; SSEL low twice; done at cycle 288 after acceptance; slave model servo_pwm0_high_new=0x0400.
- Read: cmd_rd_count=3, slave model regs {0x4A53, 0x00A5, 0x0123} → MOSI 0x8000, 0x8000, 0x8000, 0x0000; rd_valid ×3 with (0, 0x4A53), (1, 0x00A5), (2, 0x0123); done after 4 frames.
- cmd_rd_count=0 → behaves as count 1: 2 frames, a single rd_valid with (0, 0x4A53).
- Timing with HALF_PERIOD=4: SPI_CLK low/high phases each exactly 4 cycles; SSEL high ≥8 cycles between frames; MOSI stable across every falling edge.
- cmd_valid pulsed mid-read → cmd_ready=0, no extra frames; a second write offered after done → accepted on the next cycle.
- SYS_RST_N asserted during bit 7 of a frame → SSEL=1, SPI_CLK=1, busy=0 in the same cycle; no done or rd_valid; a subsequent command runs normally.
